// File: rtl/dmem_responder.sv
// Data-side memory responder: doubleword RAM with byte-lane stores and extended loads,
// plus an MMIO window with a console TX FIFO, a cycle counter and misaligned-access capture.
module dmem_responder #(
    parameter int unsigned RAM_WORDS  = 1024,
    parameter logic [63:0] MMIO_BASE  = 64'h0000_0000_1000_0000,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] addr,
    input  logic [63:0] writeData,
    input  logic        memWrite,
    input  logic [2:0]  memType,
    output logic [63:0] readData,
    output logic        txValid,
    output logic [7:0]  txData,
    input  logic        txReady,
    output logic        misaligned
);

    localparam int unsigned IDX_W     = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W     = PTR_W + 1;
    localparam logic [63:0] RAM_BYTES = 64'(RAM_WORDS) << 3;
    localparam logic [63:0] MMIO_END  = MMIO_BASE + 64'd32;

    typedef enum logic [1:0] {
        REG_TXDATA  = 2'd0,
        REG_STATUS  = 2'd1,
        REG_CYCLE   = 2'd2,
        REG_ERRADDR = 2'd3
    } mmio_reg_e;

    // Storage and state
    logic [63:0]      r_mem [RAM_WORDS];
    logic [7:0]       r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;
    logic             r_misal;
    logic [63:0]      r_erraddr;
    logic [63:0]      r_cycle;

    // Decode
    logic             w_is_ram;
    logic             w_is_mmio;
    logic             w_size_d;
    logic             w_mmio_ok;
    mmio_reg_e        w_mmio_reg;
    logic [2:0]       w_off;
    logic [IDX_W-1:0] w_word_idx;
    logic [63:0]      w_ram_word;
    logic [63:0]      w_ram_shift;
    logic [63:0]      w_ram_load;
    logic [7:0]       w_size_mask;
    logic [7:0]       w_lane_mask;
    logic [63:0]      w_wdata_sh;
    logic [63:0]      w_status;

    // Control
    logic             w_ram_we;
    logic             w_push_req;
    logic             w_push;
    logic             w_push_drop;
    logic             w_pop;
    logic             w_full;
    logic             w_status_wr;
    logic             w_misal_evt;

    assign w_is_ram   = (addr < RAM_BYTES);
    assign w_is_mmio  = !w_is_ram && (addr >= MMIO_BASE) && (addr < MMIO_END);
    assign w_size_d   = (memType[1:0] == 2'b11);
    assign w_off      = addr[2:0];
    assign w_word_idx = addr[IDX_W+2:3];
    assign w_mmio_reg = mmio_reg_e'(addr[4:3]);
    assign w_mmio_ok  = w_is_mmio && w_size_d && !misaligned;

    // NOTE: every signal written in an always_comb gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        misaligned  = 1'b0;
        w_size_mask = 8'h00;
        case (memType[1:0])
            2'b00: begin
                misaligned  = 1'b0;
                w_size_mask = 8'h01;
            end
            2'b01: begin
                misaligned  = addr[0];
                w_size_mask = 8'h03;
            end
            2'b10: begin
                misaligned  = |addr[1:0];
                w_size_mask = 8'h0F;
            end
            default: begin
                misaligned  = |addr[2:0];
                w_size_mask = 8'hFF;
            end
        endcase
    end

    assign w_lane_mask = w_size_mask << w_off;
    assign w_wdata_sh  = writeData << {w_off, 3'b000};
    assign w_ram_word  = r_mem[w_word_idx];
    assign w_ram_shift = w_ram_word >> {w_off, 3'b000};

    always_comb begin
        w_ram_load = w_ram_shift;
        case (memType)
            3'b000:  w_ram_load = {{56{w_ram_shift[7]}},  w_ram_shift[7:0]};
            3'b001:  w_ram_load = {{48{w_ram_shift[15]}}, w_ram_shift[15:0]};
            3'b010:  w_ram_load = {{32{w_ram_shift[31]}}, w_ram_shift[31:0]};
            3'b100:  w_ram_load = {56'd0, w_ram_shift[7:0]};
            3'b101:  w_ram_load = {48'd0, w_ram_shift[15:0]};
            3'b110:  w_ram_load = {32'd0, w_ram_shift[31:0]};
            default: w_ram_load = w_ram_shift;
        endcase
    end

    assign txValid  = (r_count != '0);
    assign txData   = txValid ? r_fifo[r_rd_ptr] : 8'h00;
    assign w_full   = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_status = {48'd0, 8'(r_count), 4'd0, r_misal, r_ovf, !txValid, w_full};

    always_comb begin
        readData = 64'd0;
        if (!misaligned) begin
            if (w_is_ram) begin
                readData = w_ram_load;
            end else if (w_mmio_ok) begin
                case (w_mmio_reg)
                    REG_STATUS:  readData = w_status;
                    REG_CYCLE:   readData = r_cycle;
                    REG_ERRADDR: readData = r_erraddr;
                    default:     readData = 64'd0;
                endcase
            end
        end
    end

    assign w_ram_we    = memWrite && w_is_ram && !misaligned;
    assign w_push_req  = memWrite && w_mmio_ok && (w_mmio_reg == REG_TXDATA);
    assign w_status_wr = memWrite && w_mmio_ok && (w_mmio_reg == REG_STATUS);
    assign w_pop       = txValid && txReady;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_push      = w_push_req && (!w_full || w_pop);
    assign w_push_drop = w_push_req && !w_push;
    // Sub-doubleword MMIO accesses are silently ignored and never raise the flag.
    assign w_misal_evt = misaligned && !(w_is_mmio && !w_size_d)
                         && (memWrite || w_is_ram || w_is_mmio);

    // NOTE: RAM and FIFO storage have no reset; only the pointers, count and flags do. A store
    // presented while reset is high is blocked so it is not committed.
    always_ff @(posedge clk) begin
        if (!reset && w_ram_we) begin
            for (int b = 0; b < 8; b++) begin
                if (w_lane_mask[b]) begin
                    r_mem[w_word_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
                end
            end
        end
        if (!reset && w_push) begin
            r_fifo[r_wr_ptr] <= writeData[7:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_ovf     <= 1'b0;
            r_misal   <= 1'b0;
            r_erraddr <= 64'd0;
            r_cycle   <= 64'd0;
        end else begin
            r_cycle <= r_cycle + 64'd1;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            // Set takes priority over a same-cycle STATUS clear.
            if (w_push_drop) begin
                r_ovf <= 1'b1;
            end else if (w_status_wr && writeData[2]) begin
                r_ovf <= 1'b0;
            end
            if (w_misal_evt) begin
                r_misal   <= 1'b1;
                r_erraddr <= addr;
            end else if (w_status_wr && writeData[3]) begin
                r_misal <= 1'b0;
            end
        end
    end

endmodule
